// File: rtl/sobel_pkg.sv
// Shared constants and FSM encoding for the Sobel frame store.
// Frame geometry here is the production default; the top overrides it per instance.
package sobel_pkg;

   localparam int IMG_W  = 640;
   localparam int IMG_H  = 480;
   localparam int PIX_W  = 8;
   localparam int WIN_W  = 9 * PIX_W;
   localparam int NPIX   = IMG_W * IMG_H;
   localparam int NWIN   = (IMG_W - 2) * (IMG_H - 2);
   localparam int ADDR_W = $clog2(NPIX);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_SHIFT,
      ST_WAIT,
      ST_DONE
   } state_t;

endpackage

// File: rtl/sobel_frame_ram.sv
// Single-port frame RAM with registered read data (one-cycle read latency).
// Contents are deliberately not reset; the loader always rewrites a full frame.
module sobel_frame_ram
   import sobel_pkg::*;
#(
   parameter int DEPTH = sobel_pkg::NPIX,
   parameter int AW    = sobel_pkg::ADDR_W,
   parameter int DW    = sobel_pkg::PIX_W
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/sobel_frame_mem.sv
// Frame store plus 3x3 window server: loads one raster frame, then returns one
// interior-pixel neighbourhood per request in row-major order.
module sobel_frame_mem #(
   parameter int IMG_W = sobel_pkg::IMG_W,
   parameter int IMG_H = sobel_pkg::IMG_H,
   parameter int PIX_W = sobel_pkg::PIX_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [PIX_W-1:0]   mem_bus_in,
   input  logic               mem_data_strobe,
   input  logic               mem_bus_rw,
   output logic [9*PIX_W-1:0] mem_bus_out,
   output logic               win_valid,
   output logic               win_busy,
   output logic               frame_loaded,
   output logic               win_done
);
   import sobel_pkg::*;

   localparam int N_PIX = IMG_W * IMG_H;
   localparam int AW    = $clog2(N_PIX);
   localparam int CW    = $clog2(IMG_W);
   localparam int RW    = $clog2(IMG_H);
   localparam int LW    = 3 * PIX_W;

   localparam logic [AW-1:0] LAST_ADDR = AW'(N_PIX - 1);
   localparam logic [AW-1:0] ROW_STEP  = AW'(IMG_W);
   localparam logic [CW-1:0] COL_FIRST = CW'(1);
   localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 2);
   localparam logic [RW-1:0] ROW_FIRST = RW'(1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 2);

   state_t          state, state_nxt;
   logic            rw_q;
   logic [AW-1:0]   wr_addr, rd_addr, ram_addr;
   logic [PIX_W-1:0] rdata;
   logic [RW-1:0]   win_row;
   logic [CW-1:0]   win_col;
   logic [AW-1:0]   row_base;
   logic [AW-1:0]   iss_base;
   logic [CW-1:0]   iss_col;
   logic [1:0]      iss_j, iss_row;
   logic [3:0]      iss_cnt;
   logic            p1_vld, p1_last, p2_vld, p2_last;
   logic [1:0]      p1_row, p2_row;
   logic [LW-1:0]   row0, row1, row2;

   logic mode_exit, we, accept, issue, issue_last, emit, last_win;

   // Leaving window mode abandons the frame: everything restarts from a fresh load.
   assign mode_exit  = rw_q & ~mem_bus_rw;
   assign we         = mem_data_strobe & ~mem_bus_rw & ~frame_loaded & ~mode_exit;
   assign accept     = mem_data_strobe & mem_bus_rw & frame_loaded & ~win_done &
                       (state == ST_IDLE) & ~mode_exit;
   assign issue      = (state == ST_FILL) || (state == ST_SHIFT);
   assign issue_last = ((state == ST_FILL) && (iss_cnt == 4'd8)) ||
                       ((state == ST_SHIFT) && (iss_cnt == 4'd2));
   assign emit       = p2_vld & p2_last & ~mode_exit;
   assign last_win   = (win_row == ROW_LAST) && (win_col == COL_LAST);
   assign ram_addr   = we ? wr_addr : rd_addr;
   assign win_busy   = (state == ST_FILL) || (state == ST_SHIFT) || (state == ST_WAIT);
   assign win_done   = (state == ST_DONE);

   sobel_frame_ram #(
      .DEPTH (N_PIX),
      .AW    (AW),
      .DW    (PIX_W)
   ) u_ram (
      .clk   (clk),
      .we    (we),
      .addr  (ram_addr),
      .wdata (mem_bus_in),
      .rdata (rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // WAIT spans the address register plus the RAM read stage (two cycles).
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept) state_nxt = (win_col == COL_FIRST) ? ST_FILL : ST_SHIFT;
         ST_FILL,
         ST_SHIFT: if (issue_last) state_nxt = ST_WAIT;
         ST_WAIT:  if (emit) state_nxt = last_win ? ST_DONE : ST_IDLE;
         ST_DONE:  state_nxt = ST_DONE;
         default:  state_nxt = ST_IDLE;
      endcase
      if (mode_exit) state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rw_q         <= 1'b0;
         wr_addr      <= '0;
         rd_addr      <= '0;
         frame_loaded <= 1'b0;
         win_row      <= ROW_FIRST;
         win_col      <= COL_FIRST;
         row_base     <= '0;
         iss_base     <= '0;
         iss_col      <= '0;
         iss_j        <= '0;
         iss_row      <= '0;
         iss_cnt      <= '0;
         p1_vld       <= 1'b0;
         p1_last      <= 1'b0;
         p1_row       <= '0;
         p2_vld       <= 1'b0;
         p2_last      <= 1'b0;
         p2_row       <= '0;
         row0         <= '0;
         row1         <= '0;
         row2         <= '0;
         mem_bus_out  <= '0;
         win_valid    <= 1'b0;
      end else begin
         rw_q      <= mem_bus_rw;
         win_valid <= 1'b0;
         if (mode_exit) begin
            wr_addr      <= '0;
            frame_loaded <= 1'b0;
            win_row      <= ROW_FIRST;
            win_col      <= COL_FIRST;
            row_base     <= '0;
            p1_vld       <= 1'b0;
            p2_vld       <= 1'b0;
         end else begin
            if (we) begin
               wr_addr <= wr_addr + AW'(1);
               if (wr_addr == LAST_ADDR) frame_loaded <= 1'b1;
            end
            // FILL walks columns c-1..c+1; SHIFT only fetches the new column c+1.
            if (accept) begin
               iss_base <= row_base;
               iss_col  <= (win_col == COL_FIRST) ? win_col - CW'(1) : win_col + CW'(1);
               iss_j    <= '0;
               iss_row  <= '0;
               iss_cnt  <= '0;
            end
            p1_vld  <= issue;
            p1_last <= issue_last;
            p1_row  <= iss_row;
            if (issue) begin
               rd_addr <= iss_base + AW'(iss_col);
               iss_cnt <= iss_cnt + 4'd1;
               if ((state == ST_SHIFT) || (iss_j == 2'd2)) begin
                  iss_base <= iss_base + ROW_STEP;
                  iss_row  <= iss_row + 2'd1;
                  iss_j    <= '0;
                  if (state == ST_FILL) iss_col <= iss_col - CW'(2);
               end else begin
                  iss_j   <= iss_j + 2'd1;
                  iss_col <= iss_col + CW'(1);
               end
            end
            p2_vld  <= p1_vld;
            p2_last <= p1_last;
            p2_row  <= p1_row;
            // Each window row slides left by one pixel per captured read.
            if (p2_vld) begin
               case (p2_row)
                  2'd0:    row0 <= {row0[LW-PIX_W-1:0], rdata};
                  2'd1:    row1 <= {row1[LW-PIX_W-1:0], rdata};
                  default: row2 <= {row2[LW-PIX_W-1:0], rdata};
               endcase
            end
            if (emit) begin
               mem_bus_out <= {row0, row1, row2[LW-PIX_W-1:0], rdata};
               win_valid   <= 1'b1;
               if (win_col == COL_LAST) begin
                  if (win_row != ROW_LAST) begin
                     win_row  <= win_row + RW'(1);
                     win_col  <= COL_FIRST;
                     row_base <= row_base + ROW_STEP;
                  end
               end else begin
                  win_col <= win_col + CW'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sobel_frame_mem.sv
// Self-checking bench for sobel_frame_mem on a reduced 6x5 frame, using a
// pixel-array reference model of the window order, contents and latency.
module tb_sobel_frame_mem;

   localparam int TW = 6;
   localparam int TH = 5;
   localparam int PW = 8;
   localparam int WW = 9 * PW;
   localparam int NP = TW * TH;

   logic          clk = 1'b0;
   logic          reset;
   logic [PW-1:0] mem_bus_in;
   logic          mem_data_strobe;
   logic          mem_bus_rw;
   logic [WW-1:0] mem_bus_out;
   logic          win_valid;
   logic          win_busy;
   logic          frame_loaded;
   logic          win_done;

   int            pass_cnt = 0;
   int            chk_cnt  = 0;
   int            frame [NP];
   logic [WW-1:0] last_win = '0;
   logic [WW-1:0] exp_q [$];

   sobel_frame_mem #(
      .IMG_W (TW),
      .IMG_H (TH),
      .PIX_W (PW)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .mem_bus_in      (mem_bus_in),
      .mem_data_strobe (mem_data_strobe),
      .mem_bus_rw      (mem_bus_rw),
      .mem_bus_out     (mem_bus_out),
      .win_valid       (win_valid),
      .win_busy        (win_busy),
      .frame_loaded    (frame_loaded),
      .win_done        (win_done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WW-1:0] model_win(input int r, input int c);
      logic [WW-1:0] w;
      w = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            w = {w[WW-PW-1:0], 8'(frame[(r - 1 + i) * TW + (c - 1 + j)])};
      return w;
   endfunction

   task automatic do_request(input bit expect_pulse, input int exp_lat,
                             input logic [WW-1:0] exp_win, input bit poke);
      int lat;
      bit seen;
      lat = 0;
      seen = 0;
      mem_bus_rw = 1'b1;
      mem_data_strobe = 1'b1;
      step();
      mem_data_strobe = 1'b0;
      if (expect_pulse) begin
         chk_cnt++;
         if (win_busy !== 1'b1) $display("FAIL busy_rise got %b want 1", win_busy);
         else pass_cnt++;
      end
      for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
         step();
         mem_data_strobe = 1'b0;
         if (win_valid === 1'b1) begin
            seen = 1;
            lat = cyc;
         end else if (poke && cyc == 2) begin
            mem_data_strobe = 1'b1;
         end
      end
      chk_cnt++;
      if (expect_pulse) begin
         if (!seen || lat != exp_lat)
            $display("FAIL latency got %0d (seen=%0d) want %0d", lat, seen, exp_lat);
         else pass_cnt++;
         chk_cnt++;
         if (mem_bus_out !== exp_win)
            $display("FAIL window got %h want %h", mem_bus_out, exp_win);
         else pass_cnt++;
         chk_cnt++;
         if (win_busy !== 1'b0) $display("FAIL busy_fall got %b want 0", win_busy);
         else pass_cnt++;
         last_win = exp_win;
      end else begin
         if (seen) $display("FAIL no_pulse got pulse after %0d cycles want none", lat);
         else pass_cnt++;
      end
   endtask

   // mode 0: ramp, 1: random with idle gaps, 2: reload the stored frame.
   task automatic load_frame(input int mode);
      mem_bus_rw = 1'b0;
      mem_data_strobe = 1'b0;
      step();
      step();
      for (int a = 0; a < NP; a++) begin
         if (mode == 0) frame[a] = a % 256;
         else if (mode == 1) frame[a] = $urandom_range(0, 255);
         if (mode != 0 && $urandom_range(0, 3) == 0) begin
            mem_data_strobe = 1'b0;
            mem_bus_in = 8'($urandom_range(0, 255));
            step();
         end
         if (a == NP - 1) begin
            chk_cnt++;
            if (frame_loaded !== 1'b0) $display("FAIL load_early got %b want 0", frame_loaded);
            else pass_cnt++;
         end
         mem_data_strobe = 1'b1;
         mem_bus_in = 8'(frame[a]);
         step();
      end
      mem_data_strobe = 1'b0;
      chk_cnt++;
      if (frame_loaded !== 1'b1) $display("FAIL load_done got %b want 1", frame_loaded);
      else pass_cnt++;
      // One surplus write that must not wrap onto pixel 0.
      mem_data_strobe = 1'b1;
      mem_bus_in = 8'hAA;
      step();
      mem_data_strobe = 1'b0;
      step();
   endtask

   task automatic serve_all(input bit poke_rand);
      for (int r = 1; r <= TH - 2; r++)
         for (int c = 1; c <= TW - 2; c++) begin
            exp_q.push_back(model_win(r, c));
            do_request(1'b1, (c == 1) ? 11 : 5, exp_q.pop_front(),
                       poke_rand ? 1'($urandom_range(0, 1)) : 1'b0);
         end
      chk_cnt++;
      if (win_done !== 1'b1) $display("FAIL win_done got %b want 1", win_done);
      else pass_cnt++;
      do_request(1'b0, 0, '0, 1'b0);
      chk_cnt++;
      if (mem_bus_out !== last_win) $display("FAIL hold_after_done got %h want %h", mem_bus_out, last_win);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      mem_data_strobe = 1'b0;
      mem_bus_rw = 1'b0;
      mem_bus_in = '0;
      repeat (3) step();
      reset = 1'b0;
      step();
      chk_cnt++;
      if ({mem_bus_out, win_valid, win_busy, frame_loaded, win_done} !== '0)
         $display("FAIL reset_outputs got %h/%b%b%b%b want 0", mem_bus_out, win_valid, win_busy, frame_loaded, win_done);
      else pass_cnt++;
   endtask

   task automatic test_early_request();
      mem_bus_rw = 1'b0;
      for (int a = 0; a < 10; a++) begin
         mem_data_strobe = 1'b1;
         mem_bus_in = 8'(a);
         step();
      end
      mem_data_strobe = 1'b0;
      do_request(1'b0, 0, '0, 1'b0);
      chk_cnt++;
      if (frame_loaded !== 1'b0 || win_busy !== 1'b0)
         $display("FAIL early_state got loaded=%b busy=%b want 0 0", frame_loaded, win_busy);
      else pass_cnt++;
   endtask

   task automatic test_ramp_windows();
      load_frame(0);
      serve_all(1'b1);
   endtask

   task automatic test_mode_change();
      mem_bus_rw = 1'b0;
      step();
      step();
      chk_cnt++;
      if (frame_loaded !== 1'b0 || win_done !== 1'b0)
         $display("FAIL mode_clear got loaded=%b done=%b want 0 0", frame_loaded, win_done);
      else pass_cnt++;
      chk_cnt++;
      if (mem_bus_out !== last_win) $display("FAIL mode_hold got %h want %h", mem_bus_out, last_win);
      else pass_cnt++;
   endtask

   task automatic test_abort_random();
      bit seen;
      load_frame(1);
      mem_bus_rw = 1'b1;
      mem_data_strobe = 1'b1;
      step();
      mem_data_strobe = 1'b0;
      repeat (3) step();
      mem_bus_rw = 1'b0;
      seen = 0;
      repeat (15) begin
         step();
         if (win_valid === 1'b1) seen = 1;
      end
      chk_cnt++;
      if (seen) $display("FAIL abort_pulse got pulse want none");
      else pass_cnt++;
      chk_cnt++;
      if (mem_bus_out !== last_win || frame_loaded !== 1'b0)
         $display("FAIL abort_state got %h loaded=%b want %h loaded=0", mem_bus_out, frame_loaded, last_win);
      else pass_cnt++;
      load_frame(2);
      serve_all(1'b1);
   endtask

   task automatic test_reset_mid_fill();
      mem_bus_rw = 1'b0;
      step();
      load_frame(2);
      mem_bus_rw = 1'b1;
      mem_data_strobe = 1'b1;
      step();
      mem_data_strobe = 1'b0;
      repeat (4) step();
      reset = 1'b1;
      #1;
      chk_cnt++;
      if ({mem_bus_out, win_valid, win_busy, frame_loaded, win_done} !== '0)
         $display("FAIL reset_mid_fill got %h/%b%b%b%b want 0", mem_bus_out, win_valid, win_busy, frame_loaded, win_done);
      else pass_cnt++;
      step();
      reset = 1'b0;
      step();
      load_frame(2);
      serve_all(1'b0);
   endtask

   initial begin
      test_reset();
      test_early_request();
      test_ramp_windows();
      test_mode_change();
      test_abort_random();
      test_reset_mid_fill();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
